// File: rtl/alu_mul_seq.sv
// Multi-cycle 16x16 shift-and-add multiplier that borrows the external ALU16 for
// every add and doubling step. It returns the low 16 bits of a*b.
module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DBL,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] mult;
    logic [4:0]  cnt;

    // The ALU flags carry no information that this sequencer needs.
    logic unused_flags;
    assign unused_flags = &{1'b0, alu_zr, alu_ng};

    // NOTE: sequential state uses <= so that every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            mcand <= '0;
            mult  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        mcand <= a;
                        mult  <= b;
                        cnt   <= '0;
                    end
                end
                S_ADD: acc <= alu_out;
                S_DBL: begin
                    mcand <= alu_out;
                    mult  <= mult >> 1;
                    cnt   <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        alu_x     = '0;
        alu_y     = '0;
        alu_zx    = 1'b0;
        alu_nx    = 1'b0;
        alu_zy    = 1'b0;
        alu_ny    = 1'b0;
        alu_f     = 1'b0;
        alu_no    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (EARLY_EXIT && b == 16'd0) state_nxt = S_DONE;
                    else if (b[0])                state_nxt = S_ADD;
                    else                          state_nxt = S_DBL;
                end
            end
            S_ADD: begin
                alu_x     = acc;
                alu_y     = mcand;
                alu_f     = 1'b1;
                state_nxt = S_DBL;
            end
            S_DBL: begin
                alu_x = mcand;
                alu_y = mcand;
                alu_f = 1'b1;
                // mult[15:1] is the multiplier that remains after this shift.
                if ((EARLY_EXIT && mult[15:1] == 15'd0) || cnt == 5'd15) state_nxt = S_DONE;
                else if (mult[1])                                         state_nxt = S_ADD;
                else                                                      state_nxt = S_DBL;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy    = (state == S_ADD) || (state == S_DBL);
    assign done    = (state == S_DONE);
    assign product = acc;

endmodule
